// File: rtl/divider8.sv
// divider8: multi-cycle unsigned 8-bit restoring divider reusing one subtractor8 per iteration.
// Divide-by-zero follows RISC-V DIVU/REMU: quotient all ones, remainder = dividend.

module subtractor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrowout,
  output logic       underflow
);
  assign {borrowout, diff} = {1'b0, a} - {1'b0, b};
  assign underflow = (a[7] ^ b[7]) & (diff[7] ^ a[7]);
endmodule

module divider8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       divzero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] r, q, d, rs, diff, r_nxt, q_nxt;
  logic [2:0] cnt;
  logic borrow, qbit, unused_underflow;
  assign rs = {r[6:0], q[7]};
  subtractor8 u_sub (
    .a(rs),
    .b(d),
    .diff(diff),
    .borrowout(borrow),
    .underflow(unused_underflow)
  );
  assign qbit = ~borrow;
  assign r_nxt = qbit ? diff : rs;
  assign q_nxt = {q[6:0], qbit};
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) state_nxt = start ? (divisor == 8'd0 ? DONE : RUN) : IDLE;
    else if (state == RUN) state_nxt = cnt == 3'd7 ? DONE : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      divzero <= 1'b0;
    end else if (state == IDLE && start) begin
      if (divisor != 8'd0) begin
        q <= dividend;
        d <= divisor;
        r <= '0;
        cnt <= '0;
      end else begin
        quotient <= 8'hFF;
        remainder <= dividend;
        divzero <= 1'b1;
      end
    end else if (state == RUN) begin
      r <= r_nxt;
      q <= q_nxt;
      cnt <= cnt + 3'd1;
      // last iteration: publish the next-state values on the same edge
      if (cnt == 3'd7) begin
        quotient <= q_nxt;
        remainder <= r_nxt;
        divzero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_divider8.sv
// tb_divider8: directed vectors feed a scoreboard queue; a negedge monitor checks timing and results.

module tb_divider8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient, remainder;
  logic       busy, done, divzero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         t0;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  divider8 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .divzero(divzero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accepted request: sampled on the next rising edge, expected result queued.
  task automatic issue(input logic [7:0] dd, input logic [7:0] dv,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'hA5;
    divisor = 8'h5A;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.t0 = cyc;
    e.lat = edz ? 1 : 9;
    sb.push_back(e);
  endtask

  // Request the DUT must ignore: nothing queued.
  task automatic pulse(input logic [7:0] dd, input logic [7:0] dv);
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("wait_idle_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_overlap", int'(busy & done), 0);
      if (sb.size() != 0) begin
        exp_t e;
        logic eb, ed;
        e = sb[0];
        eb = e.lat == 9 && cyc >= e.t0 && cyc < e.t0 + 8;
        ed = cyc == e.t0 + e.lat - 1;
        check("busy", int'(busy), int'(eb));
        check("done", int'(done), int'(ed));
        if (done && ed) begin
          check("quotient", int'(quotient), int'(e.q));
          check("remainder", int'(remainder), int'(e.r));
          check("divzero", int'(divzero), int'(e.dz));
          void'(sb.pop_front());
        end else if (cyc >= e.t0 + e.lat - 1) begin
          void'(sb.pop_front());
        end
      end else begin
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_divzero", int'(divzero), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    wait_idle();
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    wait_idle();
    issue(8'd5, 8'd200, 8'd0, 8'd5, 1'b0);
    wait_idle();
    issue(8'd255, 8'd200, 8'd1, 8'd55, 1'b0);
    wait_idle();
    issue(8'd0, 8'd9, 8'd0, 8'd0, 1'b0);
    wait_idle();
    issue(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1);
    wait_idle();
    issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
    wait_idle();
    issue(8'd128, 8'd128, 8'd1, 8'd0, 1'b0);
    wait_idle();

    // starts at cycles 3 and 9 are ignored; cycle 10 is accepted
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (2) @(posedge clk);
    pulse(8'd50, 8'd5);
    repeat (5) @(posedge clk);
    pulse(8'd50, 8'd5);
    issue(8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    wait_idle();

    // asynchronous reset during cycle 4 aborts the division
    issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_divzero", int'(divzero), 0);
    @(posedge clk);
    #1;
    check("abort_hold_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/divider8.md
# divider8

Multi-cycle unsigned 8-bit restoring divider for the RISC-V ALU, built as the stage directly downstream of `subtractor8`. It instantiates one `subtractor8` and reuses it every cycle as its trial-subtract stage. It takes a dividend and divisor on a one-cycle start strobe and produces quotient and remainder after 8 iterations. It pulses `done` when the result is ready. Divide-by-zero results follow RISC-V DIVU/REMU conventions.

## Interface
- Parameters: none. The datapath is fixed at 8 bits to match `subtractor8`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request strobe; sampled only in IDLE
- `dividend`  in  8  unsigned numerator; sampled with an accepted `start`
- `divisor`  in  8  unsigned denominator; sampled with an accepted `start`
- `quotient`  out  8  registered result; holds until the next result is written
- `remainder`  out  8  registered result; holds until the next result is written
- `busy`  out  1  high while iterating (RUN)
- `done`  out  1  one-cycle pulse; results valid in the same cycle
- `divzero`  out  1  registered; set with a result whose divisor was 0, cleared with any other result

## Operation
- Internal registers: R[7:0] partial remainder, Q[7:0] shifting dividend/quotient, D[7:0] divisor, cnt[2:0], state.
- FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1, `divisor`≠0:
  - Q←`dividend`, D←`divisor`, R←0, cnt←0.
  - Next state RUN.
- IDLE, `start`=1, `divisor`=0:
  - `quotient`←8'hFF, `remainder`←`dividend`, `divzero`←1.
  - Next state DONE. RUN is skipped.
- RUN, one iteration per cycle:
  - Rs = {R[6:0], Q[7]}.
  - `subtractor8` computes diff = Rs − D, with borrowout=1 iff Rs < D unsigned.
  - qbit = ~borrowout.
  - R←qbit ? diff : Rs.
  - Q←{Q[6:0], qbit}.
  - cnt←cnt+1.
- RUN, when cnt=7: in the same edge, write `quotient`/`remainder` from the next-state Q/R, clear `divzero`, and go to DONE.
- 9-bit headroom is not needed. After k iterations R < min(D, 2^k), so Rs ≤ 255 always fits in 8 bits. The `underflow` output of `subtractor8` is unused.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued.
- `dividend`/`divisor` changes after acceptance have no effect on the operation in flight.

## Timing
- Cycle 0 is the edge on which `start` is sampled high in IDLE.
- Normal operation:
  - `busy`=1 in cycles 1–8.
  - `done`=1 in cycle 9, with the new `quotient`/`remainder` visible from cycle 9.
  - The earliest next accepted `start` is at cycle 10, because the FSM is back in IDLE.
- Divide-by-zero: `done`=1 and results visible in cycle 1, with `busy` never asserted. The next `start` can be accepted at cycle 2.
- `busy` and `done` are never high simultaneously.
- Reset (`rst`=1, any time, asynchronous):
  - state←IDLE.
  - All outputs and internal registers become 0: `quotient`, `remainder`, `busy`, `done`, `divzero`, R, Q, D, cnt.
- Reset mid-RUN aborts the operation: no `done` pulse, and the previous results are lost (they read 0).
- First `start` after reset deasserts: accepted on the first rising edge with `rst`=0.

## Test plan
- 100/7 → `busy` high cycles 1–8; `done` pulse cycle 9; `quotient`=14, `remainder`=2, `divzero`=0. Also run 255/1 → 255 r 0.
- 5/200 → `quotient`=0, `remainder`=5. Also run 255/200 → 1 r 55, and 0/9 → 0 r 0.
- 42/0 → `done` in cycle 1; `quotient`=8'hFF, `remainder`=42, `divzero`=1, `busy` never high. A following 9/3 → 3 r 0 with `divzero` cleared.
- 100/7 started, then `start` with 50/5 at cycles 3 and 9 → both ignored, result 14 r 2. `start` at cycle 10 with 50/5 → `done` at cycle 19 with 10 r 0.
- 200/3 started, `rst` pulsed during cycle 4 → all outputs 0 immediately, no `done` pulse. After release, 200/3 → 66 r 2 with full 9-cycle latency.
